// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake state, coherence FSM states and
// the word offsets inside a two-word block.
package cpu_types_pkg;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

    typedef enum logic [3:0] {
        IDLE, IFETCH, WB, SNOOP, C2C0, C2C1, RD0, RD1, INV
    } coh_state_t;

    localparam logic [2:0] WORD0 = 3'b000;
    localparam logic [2:0] WORD1 = 3'b100;

    function automatic logic [31:0] blk_addr(input logic [31:0] a, input logic [2:0] off);
        return {a[31:3], off};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Two-way round-robin grant. The pointer names the favoured core and
// flips whenever a grant is consumed.
module rr_arbiter (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       gnt_vld,
    output logic       gnt
);

    logic ptr;

    assign gnt_vld = |req;
    assign gnt     = req[ptr] ? ptr : ~ptr;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            ptr <= 1'b0;
        else if (advance)
            ptr <= ~ptr;
    end

endmodule

// File: rtl/coherence_ctrl.sv
// Two-core snooping bus controller: one transaction at a time, cache-to-cache
// transfer with memory update on a modified snoop hit, queued invalidates.
module coherence_ctrl
    import cpu_types_pkg::*;
(
    input  logic             CLK,
    input  logic             nRST,
    input  logic [1:0]       iREN,
    input  logic [1:0][31:0] iaddr,
    input  logic [1:0]       dREN,
    input  logic [1:0]       dWEN,
    input  logic [1:0][31:0] daddr,
    input  logic [1:0][31:0] dstore,
    input  logic [1:0]       ccwrite,
    output logic [1:0]       iwait,
    output logic [1:0][31:0] iload,
    output logic [1:0]       dwait,
    output logic [1:0][31:0] dload,
    output logic [1:0]       ccwait,
    output logic [1:0]       ccinv,
    output logic [1:0][31:0] ccsnoopaddr,
    output logic             ramREN,
    output logic             ramWEN,
    output logic [31:0]      ramaddr,
    output logic [31:0]      ramstore,
    input  logic [31:0]      ramload,
    input  ramstate_t        ramstate
);

    coh_state_t       state, nxt;
    logic             r, o;
    logic [31:0]      blk;
    logic [1:0]       pend_inv;
    logic [1:0][31:0] pend_addr;
    logic [1:0]       areq;
    logic             gnt_vld, gnt, advance, acc;

    assign o       = ~r;
    assign acc     = (ramstate == ACCESS);
    assign advance = (state == IDLE) && gnt_vld;

    // One pointer shared by all request classes; the class is chosen first.
    always_comb begin
        if (|pend_inv)
            areq = pend_inv;
        else if (|(dREN | dWEN))
            areq = dREN | dWEN;
        else
            areq = iREN;
    end

    rr_arbiter u_arb (
        .CLK     (CLK),
        .nRST    (nRST),
        .req     (areq),
        .advance (advance),
        .gnt_vld (gnt_vld),
        .gnt     (gnt)
    );

    // Snoop-side outputs kept apart so they never depend on the snoop response.
    always_comb begin
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        case (state)
            SNOOP, C2C0: begin
                ccwait[o]      = 1'b1;
                ccsnoopaddr[o] = blk_addr(blk, WORD0);
            end
            C2C1: begin
                ccwait[o]      = 1'b1;
                ccsnoopaddr[o] = blk_addr(blk, WORD1);
            end
            INV: begin
                ccwait[o]      = 1'b1;
                ccinv[o]       = 1'b1;
                ccsnoopaddr[o] = pend_addr[r];
            end
            default: ;
        endcase
    end

    always_comb begin
        nxt      = state;
        iwait    = '1;
        dwait    = '1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            IDLE: begin
                if (gnt_vld) begin
                    if (|pend_inv)     nxt = INV;
                    else if (dWEN[gnt]) nxt = WB;
                    else if (dREN[gnt]) nxt = SNOOP;
                    else                nxt = IFETCH;
                end
            end
            IFETCH: begin
                ramREN   = 1'b1;
                ramaddr  = iaddr[r];
                iload[r] = ramload;
                if (acc) begin
                    iwait[r] = 1'b0;
                    nxt      = IDLE;
                end
            end
            WB: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[r];
                ramstore = dstore[r];
                if (acc) begin
                    dwait[r] = 1'b0;
                    nxt      = IDLE;
                end
            end
            SNOOP: nxt = ccwrite[o] ? C2C0 : RD0;
            C2C0, C2C1: begin
                if (!dREN[r]) begin
                    nxt = IDLE;
                end else begin
                    ramWEN   = 1'b1;
                    ramaddr  = blk_addr(blk, (state == C2C0) ? WORD0 : WORD1);
                    ramstore = dstore[o];
                    dload[r] = dstore[o];
                    if (acc) begin
                        dwait[r] = 1'b0;
                        nxt      = (state == C2C0) ? C2C1 : IDLE;
                    end
                end
            end
            RD0, RD1: begin
                if (!dREN[r]) begin
                    nxt = IDLE;
                end else begin
                    ramREN   = 1'b1;
                    ramaddr  = blk_addr(blk, (state == RD0) ? WORD0 : WORD1);
                    dload[r] = ramload;
                    if (acc) begin
                        dwait[r] = 1'b0;
                        nxt      = (state == RD0) ? RD1 : IDLE;
                    end
                end
            end
            INV:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            r     <= 1'b0;
            blk   <= '0;
        end else begin
            state <= nxt;
            if (advance) begin
                r   <= gnt;
                blk <= daddr[gnt];
            end
        end
    end

    // A core being snooped holds ccwrite as its response; that is not an upgrade.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pend_inv  <= '0;
            pend_addr <= '0;
        end else begin
            if (state == INV)
                pend_inv[r] <= 1'b0;
            for (int c = 0; c < 2; c++) begin
                if (ccwrite[c] && !dREN[c] && !dWEN[c] && !ccwait[c]) begin
                    pend_inv[c]  <= 1'b1;
                    pend_addr[c] <= daddr[c];
                end
            end
        end
    end

endmodule
